// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one iterative 6-bit binary-to-BCD converter between hours/minutes/seconds.
// Optional: define BCD_AUTO_REFRESH_EN to self-grant the rr channel whenever nothing is pending.
module bcd_convert_scheduler #(
  parameter int NCH = 3,
  parameter int BW  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*BW-1:0] binary_in,
  output logic [NCH*8-1:0]  bcd_out,
  output logic [NCH-1:0]    valid,
  output logic              done,
  output logic [1:0]        done_ch,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

  state_t         state;
  logic [NCH-1:0] pending;
  logic [1:0]     rr_ptr;
  logic [1:0]     cur_ch;
  logic [BW-1:0]  shreg;
  logic [3:0]     hi;
  logic [3:0]     lo;
  logic [2:0]     bit_cnt;

  logic [1:0]     grant_ch;
  logic           grant_valid;
  logic           take;
  logic [NCH-1:0] grant_mask;
  logic [2:0]     hi_adj;
  logic [3:0]     lo_adj;

  logic [BW-1:0]  bin_arr [NCH];
  logic [7:0]     slot    [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign bin_arr[i]        = binary_in[i*BW +: BW];
    assign bcd_out[i*8 +: 8] = slot[i];
  end

  // First pending channel at or after the rr pointer, wrapping modulo NCH.
  always_comb begin
    logic [1:0] idx;
    grant_valid = 1'b0;
    grant_ch    = rr_ptr;
    idx         = rr_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_valid && pending[idx]) begin
        grant_valid = 1'b1;
        grant_ch    = idx;
      end
      idx = (idx == 2'(NCH-1)) ? 2'd0 : idx + 2'd1;
    end
`ifdef BCD_AUTO_REFRESH_EN
    take = grant_valid || (state == IDLE);
`else
    take = grant_valid;
`endif
    grant_mask = (state == IDLE && take) ? (NCH'(1) << grant_ch) : '0;
  end

  // hi never exceeds 6 for a 6-bit input, so its top bit can be dropped on the shift.
  always_comb begin
    lo_adj = (lo >= 4'd5) ? lo + 4'd3 : lo;
    hi_adj = (hi >= 4'd5) ? 3'(hi + 4'd3) : hi[2:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      rr_ptr  <= 2'd0;
      cur_ch  <= 2'd0;
      shreg   <= '0;
      hi      <= 4'd0;
      lo      <= 4'd0;
      bit_cnt <= 3'd0;
      valid   <= '0;
      done    <= 1'b0;
      done_ch <= 2'd0;
      busy    <= 1'b0;
      for (int i = 0; i < NCH; i++) slot[i] <= 8'h00;
    end else begin
      pending <= (pending & ~grant_mask) | req;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            cur_ch  <= grant_ch;
            shreg   <= bin_arr[grant_ch];
            hi      <= 4'd0;
            lo      <= 4'd0;
            bit_cnt <= 3'd0;
            rr_ptr  <= (grant_ch == 2'(NCH-1)) ? 2'd0 : grant_ch + 2'd1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {hi, lo, shreg} <= {hi_adj, lo_adj, shreg, 1'b0};
          bit_cnt         <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(BW-1)) state <= STORE;
        end
        STORE: begin
          slot[cur_ch]  <= {hi, lo};
          valid[cur_ch] <= 1'b1;
          done          <= 1'b1;
          done_ch       <= cur_ch;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler (default build, auto-refresh off).
// Expected values come from decimal arithmetic and a round-robin queue model.
module tb_bcd_convert_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [17:0] binary_in;
  logic [23:0] bcd_out;
  logic [2:0]  valid;
  logic        done;
  logic [1:0]  done_ch;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int vals [3];

  always #5 clock = ~clock;

  bcd_convert_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .binary_in (binary_in),
    .bcd_out   (bcd_out),
    .valid     (valid),
    .done      (done),
    .done_ch   (done_ch),
    .busy      (busy)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] slot_of(input int ch);
    case (ch)
      0:       return bcd_out[7:0];
      1:       return bcd_out[15:8];
      default: return bcd_out[23:16];
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pack_vals();
    binary_in = {6'(vals[2]), 6'(vals[1]), 6'(vals[0])};
  endtask

  task automatic do_reset();
    req   = 3'b000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_and_wait(input logic [2:0] mask, output bit seen);
    req = mask;
    tick();
    req  = 3'b000;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: done=%b busy=%b, expected 0 0", k, done, busy);
      end
    end
    vectors++;
    if (bcd_out !== 24'h0 || valid !== 3'b000 || done_ch !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: bcd_out=%h valid=%b done_ch=%0d, expected 000000 000 0",
               bcd_out, valid, done_ch);
    end
  endtask

  task automatic test_single(input int v);
    do_reset();
    vals = '{0, v, 0};
    pack_vals();
    req = 3'b010;
    tick();
    req = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (busy !== (k <= 7) || done !== (k == 8)) begin
        miscompares++;
        $display("[TB] FAIL single_timing r+%0d: busy=%b done=%b, expected %b %b",
                 k, busy, done, (k <= 7), (k == 8));
      end
    end
    vectors++;
    if (done_ch !== 2'd1 || slot_of(1) !== to_bcd(v) || valid !== 3'b010 ||
        slot_of(0) !== 8'h00 || slot_of(2) !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL single_result v=%0d: done_ch=%0d bcd_out=%h valid=%b, expected 1 00%h00 010",
               v, done_ch, bcd_out, valid, to_bcd(v));
    end
    tick();
    vectors++;
    if (done !== 1'b0 || done_ch !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL single_pulse: done=%b done_ch=%0d, expected 0 1", done, done_ch);
    end
  endtask

  task automatic test_back_to_back(input int h, input int m, input int s);
    do_reset();
    vals = '{h, m, s};
    pack_vals();
    req = 3'b111;
    tick();
    req = 3'b000;
    for (int k = 1; k <= 24; k++) begin
      tick();
      vectors++;
      if (done !== (k % 8 == 0)) begin
        miscompares++;
        $display("[TB] FAIL b2b_done r+%0d: done=%b, expected %b", k, done, (k % 8 == 0));
      end else if (k % 8 == 0) begin
        if (done_ch !== 2'(k / 8 - 1) || slot_of(k / 8 - 1) !== to_bcd(vals[k / 8 - 1])) begin
          miscompares++;
          $display("[TB] FAIL b2b_result r+%0d: done_ch=%0d slot=%h, expected %0d %h",
                   k, done_ch, slot_of(k / 8 - 1), k / 8 - 1, to_bcd(vals[k / 8 - 1]));
        end
      end
    end
    vectors++;
    if (valid !== 3'b111 || bcd_out !== {to_bcd(s), to_bcd(m), to_bcd(h)}) begin
      miscompares++;
      $display("[TB] FAIL b2b_final: bcd_out=%h valid=%b, expected %h%h%h 111",
               bcd_out, valid, to_bcd(s), to_bcd(m), to_bcd(h));
    end
  endtask

  task automatic test_fairness();
    int exp_ch = 0;
    int count  = 0;
    do_reset();
    vals = '{$urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)};
    pack_vals();
    req = 3'b101;
    for (int cyc = 0; cyc < 70 && count < 6; cyc++) begin
      tick();
      if (done === 1'b1) begin
        vectors++;
        if (done_ch !== 2'(exp_ch) || slot_of(exp_ch) !== to_bcd(vals[exp_ch])) begin
          miscompares++;
          $display("[TB] FAIL fairness_grant %0d: done_ch=%0d slot=%h, expected %0d %h",
                   count, done_ch, slot_of(exp_ch), exp_ch, to_bcd(vals[exp_ch]));
        end
        exp_ch = (exp_ch == 0) ? 2 : 0;
        count++;
      end
    end
    req = 3'b000;
    vectors++;
    if (count != 6) begin
      miscompares++;
      $display("[TB] FAIL fairness_timeout: got %0d results, expected 6", count);
    end
  endtask

  task automatic test_boundaries();
    int  bnd [8];
    bit  seen;
    int  v1, v2;
    bnd = '{0, 9, 10, 63, $urandom_range(0, 63), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom_range(0, 63)};
    do_reset();
    vals = '{$urandom_range(0, 63), 0, 0};
    pack_vals();
    pulse_and_wait(3'b001, seen);
    vectors++;
    if (!seen || slot_of(0) !== to_bcd(vals[0])) begin
      miscompares++;
      $display("[TB] FAIL bound_ch0: seen=%0d slot=%h, expected 1 %h", seen, slot_of(0), to_bcd(vals[0]));
    end
    foreach (bnd[i]) begin
      vals[2] = bnd[i];
      pack_vals();
      pulse_and_wait(3'b100, seen);
      vectors++;
      if (!seen || done_ch !== 2'd2 || slot_of(2) !== to_bcd(bnd[i]) ||
          slot_of(0) !== to_bcd(vals[0]) || valid !== 3'b101) begin
        miscompares++;
        $display("[TB] FAIL bound_value %0d: seen=%0d done_ch=%0d bcd_out=%h valid=%b, expected 1 2 %h..%h 101",
                 bnd[i], seen, done_ch, bcd_out, valid, to_bcd(bnd[i]), to_bcd(vals[0]));
      end
    end
    // binary_in changes after the grant edge must not leak into the result
    v1 = $urandom_range(0, 63);
    v2 = v1 ^ 63;
    vals[2] = v1;
    pack_vals();
    req = 3'b100;
    tick();
    req = 3'b000;
    tick();
    tick();
    tick();
    vals[2] = v2;
    pack_vals();
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || slot_of(2) !== to_bcd(v1)) begin
      miscompares++;
      $display("[TB] FAIL mid_shift_change: seen=%0d slot=%h, expected 1 %h", seen, slot_of(2), to_bcd(v1));
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_reset();
    vals = '{$urandom_range(1, 63), $urandom_range(0, 63), $urandom_range(10, 63)};
    pack_vals();
    pulse_and_wait(3'b100, seen);
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (!seen || bcd_out !== 24'h0 || valid !== 3'b000 || done !== 1'b0 ||
        done_ch !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_clear: seen=%0d bcd_out=%h valid=%b done=%b done_ch=%0d busy=%b, expected 1 0 0 0 0 0",
               seen, bcd_out, valid, done, done_ch, busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL abort_quiet: activity seen=1, expected 0");
    end
    pulse_and_wait(3'b010, seen);
    vectors++;
    if (!seen || done_ch !== 2'd1 || bcd_out !== {16'h0, to_bcd(vals[1])} ||
        valid !== 3'b010) begin
      end
    if (!seen || done_ch !== 2'd1 || bcd_out !== {8'h00, to_bcd(vals[1]), 8'h00} ||
        valid !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL abort_recover: seen=%0d done_ch=%0d bcd_out=%h valid=%b, expected 1 1 00%h00 010",
               seen, done_ch, bcd_out, valid, to_bcd(vals[1]));
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_slot [3];
    logic [2:0] exp_valid;
    int         rr;
    int         order[$];
    logic [2:0] mask, pend;
    int         got;
    do_reset();
    exp_slot  = '{8'h00, 8'h00, 8'h00};
    exp_valid = 3'b000;
    rr        = 0;
    for (int it = 0; it < 12; it++) begin
      vals = '{$urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)};
      pack_vals();
      mask = 3'($urandom_range(1, 7));
      pend = mask;
      order.delete();
      while (pend != 3'b000) begin
        for (int j = 0; j < 3; j++) begin
          if (pend[(rr + j) % 3]) begin
            order.push_back((rr + j) % 3);
            pend[(rr + j) % 3] = 1'b0;
            rr = ((rr + j) % 3 + 1) % 3;
            break;
          end
        end
      end
      req = mask;
      tick();
      req = 3'b000;
      got = 0;
      for (int cyc = 0; cyc < 34 && got < order.size(); cyc++) begin
        tick();
        if (done === 1'b1) begin
          vectors++;
          if (done_ch !== 2'(order[got]) || slot_of(order[got]) !== to_bcd(vals[order[got]])) begin
            miscompares++;
            $display("[TB] FAIL random_result it=%0d n=%0d: done_ch=%0d slot=%h, expected %0d %h",
                     it, got, done_ch, slot_of(order[got]), order[got], to_bcd(vals[order[got]]));
          end
          exp_slot[order[got]]  = to_bcd(vals[order[got]]);
          exp_valid[order[got]] = 1'b1;
          got++;
        end
      end
      vectors++;
      if (got != order.size() || bcd_out !== {exp_slot[2], exp_slot[1], exp_slot[0]} ||
          valid !== exp_valid) begin
        miscompares++;
        $display("[TB] FAIL random_batch it=%0d: results=%0d bcd_out=%h valid=%b, expected %0d %h%h%h %b",
                 it, got, bcd_out, valid, order.size(), exp_slot[2], exp_slot[1], exp_slot[0], exp_valid);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = 3'b000;
    binary_in = '0;
    test_reset();
    test_single(45);
    test_single($urandom_range(0, 63));
    test_back_to_back(23, 59, 7);
    test_back_to_back($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    test_fairness();
    test_boundaries();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
